fast_serial_port: RTL and testbench

FAST_SERIAL_PORT -- requirements
Module: fast_serial_port

---
 rtl/fast_serial_port.sv | 148 ++++++++++++++
 tb/tb_fast_serial_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fast_serial_port.sv
// fast_serial_port: FTDI fast-serial (FSCLK/FSDI/FSDO/FSCTS) bridge with TX and RX FIFOs.
module fast_serial_port #(
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit TX_SRC     = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [7:0]                  i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic [7:0]                  o_rx_data,
    output logic                        o_rx_src,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    output logic                        o_fsclk,
    output logic                        o_fsdi,
    input  logic                        i_fsdo,
    input  logic                        i_fscts,
    output logic [$clog2(FIFO_DEPTH):0] o_tx_level,
    output logic [$clog2(FIFO_DEPTH):0] o_rx_level,
    output logic                        o_rx_overflow,
    input  logic                        i_ovf_clr,
    output logic                        o_tx_idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HALF = CLK_DIV / 2;
    localparam int DW = $clog2(HALF);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    logic [DW-1:0] r_div;
    logic          r_fsclk;
    logic [1:0]    r_fsdo_sync, r_fscts_sync;
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp;
    logic [AW:0]   r_tx_level;
    tx_state_t     r_tx_state;
    logic [8:0]    r_tx_sh;
    logic [3:0]    r_tx_cnt;
    logic          r_fsdi;
    logic [8:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wp, r_rx_rp;
    logic [AW:0]   r_rx_level;
    rx_state_t     r_rx_state;
    logic [7:0]    r_rx_sh;
    logic [3:0]    r_rx_cnt;
    logic          r_ovf;
    logic          w_wrap, w_rise, w_fall, w_rx_bit;
    logic          w_tx_push, w_tx_start, w_rx_push, w_rx_wr, w_rx_pop;
    logic [8:0]    w_rx_head;
    // Strobes flag the cycle whose closing edge drives the FSCLK transition.
    assign w_wrap = r_div == DW'(HALF - 1);
    assign w_rise = w_wrap & ~r_fsclk;
    assign w_fall = w_wrap & r_fsclk;
    assign w_rx_bit = r_fsdo_sync[1];
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div        <= '0;
            r_fsclk      <= 1'b0;
            r_fsdo_sync  <= 2'b11;
            r_fscts_sync <= 2'b00;
        end else begin
            r_div        <= w_wrap ? '0 : r_div + DW'(1);
            r_fsclk      <= r_fsclk ^ w_wrap;
            r_fsdo_sync  <= {r_fsdo_sync[0], i_fsdo};
            r_fscts_sync <= {r_fscts_sync[0], i_fscts};
        end
    end
    assign o_tx_ready = r_tx_level != FULL;
    assign w_tx_push  = i_tx_valid & o_tx_ready;
    assign w_tx_start = r_tx_state == TX_IDLE & w_fall & r_tx_level != '0 & r_fscts_sync[1];
    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= i_tx_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_level <= '0;
        end else begin
            r_tx_wp    <= r_tx_wp + AW'(w_tx_push);
            r_tx_rp    <= r_tx_rp + AW'(w_tx_start);
            r_tx_level <= r_tx_level + (AW + 1)'(w_tx_push) - (AW + 1)'(w_tx_start);
        end
    end
    // Counter tracks frame bits already driven after the start bit; 9 means the source bit is on the line.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '0;
            r_tx_cnt   <= '0;
            r_fsdi     <= 1'b1;
        end else if (w_tx_start) begin
            r_tx_state <= TX_SHIFT;
            r_tx_sh    <= {TX_SRC, r_tx_mem[r_tx_rp]};
            r_tx_cnt   <= '0;
            r_fsdi     <= 1'b0;
        end else if (r_tx_state == TX_SHIFT && w_fall) begin
            r_tx_state <= r_tx_cnt == 4'd9 ? TX_IDLE : TX_SHIFT;
            r_tx_sh    <= r_tx_sh >> 1;
            r_tx_cnt   <= r_tx_cnt + 4'd1;
            r_fsdi     <= r_tx_cnt == 4'd9 ? 1'b1 : r_tx_sh[0];
        end
    end
    assign o_fsclk    = r_fsclk;
    assign o_fsdi     = r_fsdi;
    assign o_tx_level = r_tx_level;
    assign o_tx_idle  = r_tx_state == TX_IDLE && r_tx_level == '0;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_sh    <= '0;
            r_rx_cnt   <= '0;
        end else if (w_rise) begin
            r_rx_state <= r_rx_state == RX_IDLE ? (w_rx_bit ? RX_IDLE : RX_SHIFT) :
                          (r_rx_cnt == 4'd8 ? RX_IDLE : RX_SHIFT);
            r_rx_sh    <= r_rx_state == RX_SHIFT ? {w_rx_bit, r_rx_sh[7:1]} : r_rx_sh;
            r_rx_cnt   <= r_rx_state == RX_SHIFT ? r_rx_cnt + 4'd1 : '0;
        end
    end
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign o_rx_valid = r_rx_level != '0;
    assign w_rx_pop   = o_rx_valid & i_rx_ready;
    assign w_rx_push  = w_rise & r_rx_state == RX_SHIFT & r_rx_cnt == 4'd8;
    assign w_rx_wr    = w_rx_push & (r_rx_level != FULL | w_rx_pop);
    always_ff @(posedge i_clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wp] <= {w_rx_bit, r_rx_sh};
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_level <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_rx_wp    <= r_rx_wp + AW'(w_rx_wr);
            r_rx_rp    <= r_rx_rp + AW'(w_rx_pop);
            r_rx_level <= r_rx_level + (AW + 1)'(w_rx_wr) - (AW + 1)'(w_rx_pop);
            r_ovf      <= (w_rx_push & ~w_rx_wr) | (r_ovf & ~i_ovf_clr);
        end
    end
    assign w_rx_head     = r_rx_mem[r_rx_rp];
    assign o_rx_data     = w_rx_head[7:0];
    assign o_rx_src      = w_rx_head[8];
    assign o_rx_level    = r_rx_level;
    assign o_rx_overflow = r_ovf;
endmodule

// File: tb/tb_fast_serial_port.sv
// tb_fast_serial_port: directed bench with TX/RX scoreboards for fast_serial_port.
module tb_fast_serial_port;
    localparam int CLK_DIV = 8;
    localparam int DEPTH = 4;
    localparam bit SRC = 1'b0;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic       rx_src, rx_valid, rx_ready = 1'b0;
    logic       fsclk, fsdi, fsdo = 1'b1, fscts = 1'b0;
    logic [2:0] tx_level, rx_level;
    logic       ovf, ovf_clr = 1'b0, tx_idle;
    int         checks = 0, errors = 0;
    logic [9:0] tx_q[$];
    logic [8:0] rx_q[$];

    fast_serial_port #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .TX_SRC(SRC)) dut (
        .i_clk(clk), .i_reset(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_src(rx_src), .o_rx_valid(rx_valid),
        .i_rx_ready(rx_ready), .o_fsclk(fsclk), .o_fsdi(fsdi), .i_fsdo(fsdo), .i_fscts(fscts),
        .o_tx_level(tx_level), .o_rx_level(rx_level), .o_rx_overflow(ovf),
        .i_ovf_clr(ovf_clr), .o_tx_idle(tx_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d, input bit accepted);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (accepted) tx_q.push_back({SRC, d, 1'b0});
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (fsdi !== 1'b1) lows++;
        end
    endtask

    task automatic tx_capture(input bit drop_cts, output int lat);
        logic [9:0] got, exp;
        int n = 0;
        while (fsdi !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        check("tx_start_seen", 32'(n < 500), 1);
        if (n >= 500) return;
        check("tx_start_fsclk_low", fsclk, 0);
        cycles(4);
        got[0] = fsdi;
        if (drop_cts) fscts = 1'b0;
        for (int i = 1; i < 10; i++) begin
            cycles(8);
            got[i] = fsdi;
        end
        cycles(8);
        check("tx_stop", fsdi, 1);
        check("tx_q_nonempty", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() == 0) return;
        exp = tx_q.pop_front();
        check("tx_frame", got, exp);
    endtask

    task automatic wait_fall();
        logic p = fsclk;
        bit found = 1'b0;
        for (int n = 0; n < 4 * CLK_DIV && !found; n++) begin
            @(negedge clk);
            found = p && !fsclk;
            p = fsclk;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL fsclk_fall observed=timeout expected=fall");
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic s, input bit stored);
        logic [10:0] bits;
        bits = {1'b1, s, d, 1'b0};
        wait_fall();
        for (int i = 0; i < 11; i++) begin
            fsdo = bits[i];
            wait_fall();
        end
        if (stored) rx_q.push_back({s, d});
    endtask

    task automatic rx_pop();
        logic [8:0] exp;
        check("rx_valid_before_pop", rx_valid, 1);
        check("rx_q_nonempty", 32'(rx_q.size() != 0), 1);
        if (rx_q.size() == 0) return;
        exp = rx_q.pop_front();
        check("rx_entry", {rx_src, rx_data}, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        int lat, lows, n;
        cycles(3);
        check("rst_fsclk", fsclk, 0);
        check("rst_fsdi", fsdi, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        rst = 1'b0;
        n = 0;
        while (fsclk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("fsclk_first_low", n, CLK_DIV / 2);
        n = 0;
        while (fsclk === 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("fsclk_high", n, CLK_DIV / 2);
        n = 0;
        while (fsclk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("fsclk_low", n, CLK_DIV / 2);

        fscts = 1'b1;
        cycles(3);
        push_tx(8'hA5, 1);
        cycles(1);
        check("tx_busy_not_idle", tx_idle, 0);
        tx_capture(0, lat);
        check("tx_idle_after", tx_idle, 1);
        check("tx_level_after", tx_level, 0);

        fscts = 1'b0;
        cycles(3);
        push_tx(8'h3C, 1);
        count_low(200, lows);
        check("cts_low_hold", lows, 0);
        check("cts_low_level", tx_level, 1);
        push_tx(8'h11, 1);
        push_tx(8'h22, 1);
        push_tx(8'h33, 1);
        check("tx_full_ready", tx_ready, 0);
        check("tx_full_level", tx_level, DEPTH);
        push_tx(8'h44, 0);
        check("tx_full_no_push", tx_level, DEPTH);
        fscts = 1'b1;
        tx_capture(0, lat);
        check("cts_latency", 32'(lat >= 3 && lat <= 10), 1);
        tx_capture(0, lat);
        check("b2b_gap_1", lat, 4);
        tx_capture(0, lat);
        check("b2b_gap_2", lat, 4);
        tx_capture(1, lat);
        check("b2b_gap_3", lat, 4);
        check("tx_idle_drained", tx_idle, 1);

        send_rx(8'h5A, 1'b1, 1);
        check("rx_level_one", rx_level, 1);
        rx_pop();
        check("rx_empty_after_pop", rx_valid, 0);
        send_rx(8'hC3, 1'b0, 1);
        rx_pop();
        check("rx_empty_after_pop2", rx_valid, 0);

        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'(i), i <= DEPTH);
        check("ovf_rx_level", rx_level, DEPTH);
        check("ovf_set", ovf, 1);
        for (int i = 0; i < DEPTH; i++) rx_pop();
        check("ovf_rx_drained", rx_valid, 0);
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        fscts = 1'b1;
        push_tx(8'hFF, 0);
        push_tx(8'hFF, 0);
        n = 0;
        while (fsdi !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("ff_start_seen", 32'(n < 100), 1);
        cycles(4 * CLK_DIV);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_fsdi", fsdi, 1);
        check("midrst_tx_level", tx_level, 0);
        check("midrst_tx_idle", tx_idle, 1);
        check("midrst_fsclk", fsclk, 0);
        cycles(2);
        rst = 1'b0;
        count_low(200, lows);
        check("midrst_no_resume", lows, 0);
        check("midrst_level_final", tx_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
